// File: rtl/clock_rate_monitor_if.sv
// Bus between a slow-signal source and clock_rate_monitor: enable and signal
// under test in, measurement and status out.
interface clock_rate_monitor_if #(
  parameter int W = 5
);
  logic         iEnable;
  logic         iSignal;
  logic [W-1:0] oPeriod;
  logic         oValid;
  logic         oLocked;
  logic         oFault;
  logic         oTimeout;

  modport master (
    output iEnable, iSignal,
    input  oPeriod, oValid, oLocked, oFault, oTimeout
  );

  modport slave (
    input  iEnable, iSignal,
    output oPeriod, oValid, oLocked, oFault, oTimeout
  );
endinterface

// File: rtl/clock_rate_monitor.sv
// Measures the period of a slow asynchronous signal in fast-clock cycles,
// declares lock after LOCK_N good periods and flags faults and timeouts.
module clock_rate_monitor #(
  parameter int REF_HZ = 10,
  parameter int EXP_HZ = 1,
  parameter int TOL    = 1,
  parameter int LOCK_N = 2
) (
  input  logic                 iClock_in,
  input  logic                 inReset,
  clock_rate_monitor_if.slave  bus
);
  localparam int DIV = REF_HZ / EXP_HZ;
  localparam int W   = $clog2(2 * DIV + 1);
  localparam int GW  = $clog2(LOCK_N + 1);
  localparam logic [W-1:0]  MAXC = W'(2 * DIV);
  // Lower bound clamps to 1 so a tolerance wider than DIV stays meaningful.
  localparam logic [31:0]   LO   = (DIV > TOL) ? 32'(DIV - TOL) : 32'd1;
  localparam logic [31:0]   HI   = 32'(DIV + TOL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t          state_r;
  logic            sync1_r;
  logic            sync2_r;
  logic            sync3_r;
  logic [W-1:0]    cnt_r;
  logic [GW-1:0]   goodCnt_r;
  logic            rise_s;
  logic            atMax_s;
  logic            good_s;
  logic            lockNow_s;
  logic [W-1:0]    cntInc_s;
  logic [GW-1:0]   goodInc_s;
  logic [31:0]     cntWide_s;

  assign rise_s    = sync2_r & ~sync3_r;
  assign atMax_s   = (cnt_r == MAXC);
  assign cntInc_s  = atMax_s ? cnt_r : (cnt_r + W'(1));
  assign cntWide_s = 32'(cnt_r);
  assign good_s    = (cntWide_s >= LO) && (cntWide_s <= HI);
  assign goodInc_s = goodCnt_r + GW'(1);
  assign lockNow_s = (32'(goodInc_s) >= 32'(LOCK_N));

  // Synchronizer, period counter, lock FSM and registered status outputs.
  always_ff @(posedge iClock_in or negedge inReset) begin
    if (!inReset) begin
      state_r      <= IDLE;
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      sync3_r      <= 1'b0;
      cnt_r        <= '0;
      goodCnt_r    <= '0;
      bus.oPeriod  <= '0;
      bus.oValid   <= 1'b0;
      bus.oLocked  <= 1'b0;
      bus.oFault   <= 1'b0;
      bus.oTimeout <= 1'b0;
    end else begin
      sync1_r    <= bus.iSignal;
      sync2_r    <= sync1_r;
      sync3_r    <= sync2_r;
      bus.oValid <= 1'b0;
      // Disable outranks any rise or timeout in the same cycle.
      if (!bus.iEnable) begin
        state_r      <= IDLE;
        cnt_r        <= '0;
        goodCnt_r    <= '0;
        bus.oLocked  <= 1'b0;
        bus.oFault   <= 1'b0;
        bus.oTimeout <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            cnt_r        <= '0;
            goodCnt_r    <= '0;
            bus.oLocked  <= 1'b0;
            bus.oFault   <= 1'b0;
            bus.oTimeout <= 1'b0;
            state_r      <= ARM;
          end
          ARM: begin
            if (rise_s) begin
              cnt_r     <= W'(1);
              goodCnt_r <= '0;
              state_r   <= TRACK;
            end else begin
              cnt_r <= cntInc_s;
            end
          end
          TRACK: begin
            // A rise on the saturation cycle is a (bad) period, not a timeout.
            if (rise_s) begin
              cnt_r       <= W'(1);
              bus.oPeriod <= cnt_r;
              bus.oValid  <= 1'b1;
              if (good_s) begin
                goodCnt_r <= goodInc_s;
                if (lockNow_s) begin
                  state_r     <= LOCKED;
                  bus.oLocked <= 1'b1;
                end else begin
                  state_r <= TRACK;
                end
              end else begin
                goodCnt_r <= '0;
              end
            end else if (atMax_s) begin
              cnt_r        <= '0;
              goodCnt_r    <= '0;
              bus.oTimeout <= 1'b1;
              bus.oLocked  <= 1'b0;
              state_r      <= ARM;
            end else begin
              cnt_r <= cntInc_s;
            end
          end
          LOCKED: begin
            if (rise_s) begin
              cnt_r       <= W'(1);
              bus.oPeriod <= cnt_r;
              bus.oValid  <= 1'b1;
              if (!good_s) begin
                goodCnt_r   <= '0;
                bus.oLocked <= 1'b0;
                bus.oFault  <= 1'b1;
                state_r     <= TRACK;
              end else begin
                state_r <= LOCKED;
              end
            end else if (atMax_s) begin
              cnt_r        <= '0;
              goodCnt_r    <= '0;
              bus.oTimeout <= 1'b1;
              bus.oLocked  <= 1'b0;
              state_r      <= ARM;
            end else begin
              cnt_r <= cntInc_s;
            end
          end
          default: begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            goodCnt_r   <= '0;
            bus.oLocked <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_clock_rate_monitor.sv
// Directed bench for clock_rate_monitor with default parameters (DIV=10,
// TOL=1, LOCK_N=2): period table plus enable, timeout and reset sequences.
module tb_clock_rate_monitor;
  logic clk;
  logic rstN;

  clock_rate_monitor_if #(.W(5)) bus ();

  clock_rate_monitor dut (
    .iClock_in (clk),
    .inReset   (rstN),
    .bus       (bus.slave)
  );

  typedef struct {
    int         gap;
    logic       expValid;
    logic [4:0] expPeriod;
    logic       expLocked;
    logic       expFault;
    logic       expTimeout;
  } vec_t;

  vec_t vecs [8];
  int   nTests;
  int   nFail;
  int   sinceRise;
  int   validPulses;
  int   expPulses;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every oValid pulse to catch stretched or spurious pulses.
  always @(negedge clk) begin
    if (bus.oValid === 1'b1) validPulses = validPulses + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests = nTests + 1;
    if (act !== exp) begin
      nFail = nFail + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance clock edges until 'n' edges have passed since the last rise drive.
  task automatic stepTo(input int n);
    while (sinceRise < n) begin
      @(posedge clk);
      #1;
      sinceRise = sinceRise + 1;
      if (sinceRise == 3) bus.iSignal = 1'b0;
    end
  endtask

  // Drive a rising edge 'gap' cycles after the previous one, then compare
  // outputs once the synchronizer and output register have caught up.
  task automatic checkRise(input string tag, input int gap, input logic v,
                           input logic [4:0] p, input logic l, input logic f,
                           input logic t);
    stepTo(gap);
    bus.iSignal = 1'b1;
    sinceRise = 0;
    stepTo(3);
    if (v) expPulses = expPulses + 1;
    check({tag, ".valid"},   32'(bus.oValid),   32'(v));
    check({tag, ".period"},  32'(bus.oPeriod),  32'(p));
    check({tag, ".locked"},  32'(bus.oLocked),  32'(l));
    check({tag, ".fault"},   32'(bus.oFault),   32'(f));
    check({tag, ".timeout"}, 32'(bus.oTimeout), 32'(t));
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".period"},  32'(bus.oPeriod),  32'd0);
    check({tag, ".valid"},   32'(bus.oValid),   32'd0);
    check({tag, ".locked"},  32'(bus.oLocked),  32'd0);
    check({tag, ".fault"},   32'(bus.oFault),   32'd0);
    check({tag, ".timeout"}, 32'(bus.oTimeout), 32'd0);
  endtask

  initial begin
    nTests      = 0;
    nFail       = 0;
    validPulses = 0;
    expPulses   = 0;
    sinceRise   = 0;

    //          gap  v     period  L     F     T
    vecs[0] = '{4,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{10, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{10, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{9,  1'b1, 5'd9,  1'b1, 1'b0, 1'b0};
    vecs[4] = '{11, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{13, 1'b1, 5'd13, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{10, 1'b1, 5'd10, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{10, 1'b1, 5'd10, 1'b1, 1'b1, 1'b0};

    // Reset held with the input toggling.
    rstN        = 1'b0;
    bus.iEnable = 1'b0;
    bus.iSignal = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i % 2 == 1) bus.iSignal = ~bus.iSignal;
    end
    checkAllZero("rst_hold");

    // Release with enable low: stays idle.
    rstN = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (i % 3 == 2) bus.iSignal = ~bus.iSignal;
    end
    check("idle.pulses", 32'(validPulses), 32'd0);
    checkAllZero("idle");

    bus.iSignal = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.iEnable = 1'b1;
    sinceRise   = 10;

    // Nominal lock and tolerance edges.
    for (int i = 0; i < 8; i++) begin
      checkRise($sformatf("vec%0d", i), vecs[i].gap, vecs[i].expValid,
                vecs[i].expPeriod, vecs[i].expLocked, vecs[i].expFault,
                vecs[i].expTimeout);
    end

    // One-cycle enable drop while locked with the fault flag set.
    stepTo(5);
    bus.iEnable = 1'b0;
    stepTo(6);
    check("endrop.locked", 32'(bus.oLocked), 32'd0);
    check("endrop.fault",  32'(bus.oFault),  32'd0);
    check("endrop.period", 32'(bus.oPeriod), 32'd10);
    check("endrop.valid",  32'(bus.oValid),  32'd0);
    bus.iEnable = 1'b1;
    checkRise("reen.arm", 10, 1'b0, 5'd10, 1'b0, 1'b0, 1'b0);
    checkRise("reen.p10", 10, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
    // Rise lands on the saturation cycle: bad period, no timeout.
    checkRise("sat.p20",  20, 1'b1, 5'd20, 1'b0, 1'b0, 1'b0);
    checkRise("sat.g1",   10, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
    checkRise("sat.g2",   10, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);

    // Signal stops while locked.
    stepTo(22);
    check("tmo.before",      32'(bus.oTimeout), 32'd0);
    check("tmo.beforeLock",  32'(bus.oLocked),  32'd1);
    stepTo(23);
    check("tmo.flag",        32'(bus.oTimeout), 32'd1);
    check("tmo.locked",      32'(bus.oLocked),  32'd0);
    checkRise("tmo.arm", 30, 1'b0, 5'd10, 1'b0, 1'b0, 1'b1);
    checkRise("tmo.g1",  10, 1'b1, 5'd10, 1'b0, 1'b0, 1'b1);
    checkRise("tmo.g2",  10, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset pulse between clock edges.
    stepTo(5);
    #3;
    rstN = 1'b0;
    #1;
    checkAllZero("arst");
    rstN = 1'b1;
    checkRise("arst.arm", 10, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
    checkRise("arst.g1",  10, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
    checkRise("arst.g2",  10, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);

    stepTo(8);
    check("pulse.count", 32'(validPulses), 32'(expPulses));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/clock_rate_monitor.md
Name: clock_rate_monitor

Overview:
- Consumes the slow clock produced by the clock divider, or any slow periodic signal, and measures its period in cycles of the fast system clock.
- Reports each measured period.
- Declares lock after consecutive in-tolerance periods.
- Flags period faults and a missing signal (timeout).
- Serves as the checking end of the divider: board-level self-test, plus a watchdog on divided clock domains.

Parameters:
- REF_HZ, 10, frequency of iClock_in in Hz.
- EXP_HZ, 1, expected frequency of iSignal in Hz. Expected period DIV = REF_HZ/EXP_HZ.
- TOL, 1, allowed deviation in cycles. A period P is good iff |P - DIV| <= TOL.
- LOCK_N, 2, consecutive good periods required to assert lock.
- W, $clog2(2*DIV+1), width of the period counter and oPeriod.

Ports:
- iClock_in  input  1  fast system clock, rising-edge.
- inReset  input  1  asynchronous active-low reset.
- iEnable  input  1  synchronous enable; 0 forces IDLE and clears the sticky flags.
- iSignal  input  1  slow signal under test; asynchronous to iClock_in.
- oPeriod  output  W  last measured period in cycles; saturates at 2*DIV.
- oValid  output  1  one-cycle pulse when oPeriod updates.
- oLocked  output  1  high while in LOCKED state.
- oFault  output  1  sticky; set when a bad period is seen while LOCKED.
- oTimeout  output  1  sticky; set when no rising edge is seen for 2*DIV cycles.

Behaviour:
- Reset (inReset=0, asynchronous): state=IDLE.
  - All outputs 0. cnt=0, goodcnt=0. Synchronizer flops=0.
- Input path: iSignal passes through a 2-flop synchronizer, then a third flop for edge detection.
  - rise=sync2 & ~sync3, asserted for one cycle.
  - Fixed latency: 2-3 cycles after the iSignal edge. The latency is identical for every edge, so it does not affect the measured period.
- Period counter cnt:
  - On a rise cycle: cnt<=1.
  - Otherwise: cnt<=cnt+1, saturating at 2*DIV.
  - Measured P = value of cnt in the rise cycle, i.e. the clock distance between consecutive rise pulses.
- States: IDLE, ARM, TRACK, LOCKED.
- IDLE:
  - cnt and goodcnt held at 0. oLocked=0. oFault and oTimeout cleared.
  - iEnable=1 -> ARM on the next edge.
- ARM:
  - Waits for the first rise. On rise: cnt<=1, goodcnt<=0, -> TRACK.
  - No oValid is issued from ARM (no complete period exists yet).
- TRACK:
  - On rise: oPeriod<=P, oValid=1 for that cycle.
  - If P is good: goodcnt++. When goodcnt reaches LOCK_N -> LOCKED, with oLocked=1 from the following cycle.
  - If P is bad: goodcnt<=0, stay in TRACK. oFault is unaffected.
- LOCKED:
  - On rise: oPeriod and oValid as in TRACK.
  - Bad P -> TRACK, oLocked<=0, oFault<=1, goodcnt<=0.
- Timeout: in TRACK or LOCKED, if cnt reaches 2*DIV with no rise -> oTimeout<=1, oLocked<=0, -> ARM.
  - Timeout is never checked in ARM, so ARM may wait indefinitely.
- Simultaneous rise and cnt==2*DIV in the same cycle: the rise wins.
  - P=2*DIV is reported and evaluated as a bad period; no timeout.
- iEnable=0 in any state -> IDLE on the next edge. This overrides a rise or timeout in the same cycle.
  - oPeriod keeps its last value. All other outputs go to 0.
- Reset mid-measurement: immediate return to the reset values. The partial period is discarded.
- Arithmetic:
  - |P-DIV| is computed unsigned by comparing P against DIV-TOL and DIV+TOL.
  - If DIV-TOL would go below zero, the lower bound clamps to 1.

Test Plan:
- Reset hold: inReset=0 for 20 cycles with iSignal toggling -> all outputs 0 and oPeriod=0. Release with iEnable=0 -> state remains IDLE, no oValid.
- Nominal lock (defaults, iSignal period 10 cycles, 50% duty):
  - First rise: no oValid.
  - 2nd and 3rd rises: oValid with oPeriod=10.
  - oLocked=1 from the cycle after the 3rd rise. oFault=oTimeout=0.
- Tolerance edges after lock:
  - Periods of 9 and 11 -> remain locked, oPeriod=9 then 11.
  - A period of 13 -> oPeriod=13, oLocked=0, oFault=1.
  - Two further periods of 10 -> oLocked=1 again, oFault still 1.
- Timeout: iSignal held low while locked -> at cnt=20 (20 cycles after the last rise): oTimeout=1, oLocked=0, state ARM. Resuming a period of 10 -> relock after 3 rises.
- Enable drop: iEnable=0 for 1 cycle mid-period while locked, with oFault=1 -> next edge gives oLocked=0 and oFault=0, oPeriod retained. Re-enable -> ARM, first rise yields no oValid.
- Async reset mid-period while locked: inReset pulsed low for 1 ns between clock edges -> outputs clear immediately without waiting for a clock edge. Lock reacquired after 3 rises.
